// File: rtl/alu_op_encoder_if.sv
// Request/instruction stream bundle for alu_op_encoder: one ALU request in,
// a stream of 32-bit instruction words out, plus the error pulse.
interface alu_op_encoder_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_aluctrl;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic        req_use_imm;
    logic [31:0] req_imm;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        instr_last;
    logic        err;

    modport master (
        output req_valid, req_aluctrl, req_rd, req_rs1, req_rs2, req_use_imm, req_imm,
        output instr_ready,
        input  req_ready, instr_valid, instr, instr_last, err
    );

    modport slave (
        input  req_valid, req_aluctrl, req_rd, req_rs1, req_rs2, req_use_imm, req_imm,
        input  instr_ready,
        output req_ready, instr_valid, instr, instr_last, err
    );
endinterface

// File: rtl/alu_op_encoder.sv
// Turns an ALUControl request into RV32I instruction words, expanding long
// immediates via LUI/ADDI into SCRATCH_REG. Define ALU_OP_ENCODER_CRYPTO_EN for custom crypto ops.
module alu_op_encoder #(
    parameter logic [4:0] SCRATCH_REG   = 5'd5,
    parameter logic [6:0] CRYPTO_OPCODE = 7'b0001011
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_op_encoder_if.slave   bus
);
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LUI  = 3'd1;
    localparam logic [2:0] ST_ADDI = 3'd2;
    localparam logic [2:0] ST_OP   = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd4;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    logic [2:0]  state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic        instr_last_q, instr_last_d;
    logic        err_q, err_d;
    logic [31:0] addi_word_q, addi_word_d;
    logic [31:0] op_word_q, op_word_d;
    logic        skip_addi_q, skip_addi_d;

    // Opcode decode
    logic [2:0] f3;
    logic [6:0] f7;
    logic       known, is_sub, is_shift, can_long, is_crypto, is_rng;

    always_comb begin
        f3 = 3'b000; f7 = 7'b0000000;
        known = 1'b1; is_sub = 1'b0; is_shift = 1'b0; can_long = 1'b0;
        is_crypto = 1'b0; is_rng = 1'b0;
        case (bus.req_aluctrl)
            4'b0000: begin f3 = 3'b000; can_long = 1'b1; end
            4'b0001: begin f3 = 3'b000; f7 = 7'b0100000; is_sub = 1'b1; end
            4'b0010: begin f3 = 3'b111; can_long = 1'b1; end
            4'b0011: begin f3 = 3'b110; can_long = 1'b1; end
            4'b0100: begin f3 = 3'b100; can_long = 1'b1; end
            4'b0101: begin f3 = 3'b010; can_long = 1'b1; end
            4'b0110: begin f3 = 3'b011; can_long = 1'b1; end
            4'b1010: begin f3 = 3'b001; is_shift = 1'b1; end
            4'b1100: begin f3 = 3'b101; is_shift = 1'b1; end
            4'b1011: begin f3 = 3'b101; f7 = 7'b0100000; is_shift = 1'b1; end
`ifdef ALU_OP_ENCODER_CRYPTO_EN
            4'b1101: begin f3 = 3'b010; is_crypto = 1'b1; end
            4'b1110: begin f3 = 3'b011; is_crypto = 1'b1; end
            4'b1111: begin f3 = 3'b100; is_crypto = 1'b1; is_rng = 1'b1; end
`endif
            default: known = 1'b0;
        endcase
    end

`ifndef ALU_OP_ENCODER_CRYPTO_EN
    logic unused_crypto;
    assign unused_crypto = ^CRYPTO_OPCODE;
`endif

    // (imm + 0x800) >> 12 rounds hi so that sign-extended lo lands back on imm
    logic [19:0] imm_hi;
    logic [11:0] imm_lo;
    logic        imm_short;
    assign imm_hi    = bus.req_imm[31:12] + {19'd0, bus.req_imm[11]};
    assign imm_lo    = bus.req_imm[11:0];
    assign imm_short = (bus.req_imm[31:11] == 21'h0) || (bus.req_imm[31:11] == 21'h1FFFFF);

    logic [2:0]  cls_state;
    logic [31:0] cls_word, cls_addi, cls_op;
    logic        cls_last, cls_skip;

    always_comb begin
        cls_state = ST_ERR;
        cls_word  = 32'h0;
        cls_last  = 1'b0;
        cls_addi  = 32'h0;
        cls_op    = 32'h0;
        cls_skip  = 1'b0;
        if (known) begin
            if (is_crypto) begin
                if (!bus.req_use_imm) begin
                    cls_state = ST_OP;
                    cls_last  = 1'b1;
                    cls_word  = {7'b0, is_rng ? 5'd0 : bus.req_rs2, is_rng ? 5'd0 : bus.req_rs1,
                                 f3, bus.req_rd, CRYPTO_OPCODE};
                end
            end else if (!bus.req_use_imm) begin
                cls_state = ST_OP;
                cls_last  = 1'b1;
                cls_word  = {f7, bus.req_rs2, bus.req_rs1, f3, bus.req_rd, OPC_OP};
            end else if (is_sub) begin
                cls_state = ST_ERR;
            end else if (is_shift) begin
                if (bus.req_imm[31:5] == 27'h0) begin
                    cls_state = ST_OP;
                    cls_last  = 1'b1;
                    cls_word  = {f7, bus.req_imm[4:0], bus.req_rs1, f3, bus.req_rd, OPC_OP_IMM};
                end
            end else if (imm_short) begin
                cls_state = ST_OP;
                cls_last  = 1'b1;
                cls_word  = {imm_lo, bus.req_rs1, f3, bus.req_rd, OPC_OP_IMM};
            end else if (can_long) begin
                cls_state = ST_LUI;
                cls_word  = {imm_hi, SCRATCH_REG, OPC_LUI};
                cls_addi  = {imm_lo, SCRATCH_REG, 3'b000, SCRATCH_REG, OPC_OP_IMM};
                cls_op    = {7'b0, SCRATCH_REG, bus.req_rs1, f3, bus.req_rd, OPC_OP};
                cls_skip  = (imm_lo == 12'h0);
            end
        end
    end

    logic xfer;
    assign xfer = instr_valid_q && bus.instr_ready;

    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        instr_last_d  = instr_last_q;
        err_d         = 1'b0;
        addi_word_d   = addi_word_q;
        op_word_d     = op_word_q;
        skip_addi_d   = skip_addi_q;
        case (state_q)
            ST_IDLE: if (bus.req_valid) begin
                state_d       = cls_state;
                instr_d       = cls_word;
                instr_valid_d = (cls_state != ST_ERR);
                instr_last_d  = cls_last;
                err_d         = (cls_state == ST_ERR);
                addi_word_d   = cls_addi;
                op_word_d     = cls_op;
                skip_addi_d   = cls_skip;
            end
            ST_LUI: if (xfer) begin
                state_d      = skip_addi_q ? ST_OP : ST_ADDI;
                instr_d      = skip_addi_q ? op_word_q : addi_word_q;
                instr_last_d = skip_addi_q;
            end
            ST_ADDI: if (xfer) begin
                state_d      = ST_OP;
                instr_d      = op_word_q;
                instr_last_d = 1'b1;
            end
            ST_OP: if (xfer) begin
                state_d       = ST_IDLE;
                instr_d       = 32'h0;
                instr_valid_d = 1'b0;
                instr_last_d  = 1'b0;
            end
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            instr_q       <= 32'h0;
            instr_valid_q <= 1'b0;
            instr_last_q  <= 1'b0;
            err_q         <= 1'b0;
            addi_word_q   <= 32'h0;
            op_word_q     <= 32'h0;
            skip_addi_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            instr_last_q  <= instr_last_d;
            err_q         <= err_d;
            addi_word_q   <= addi_word_d;
            op_word_q     <= op_word_d;
            skip_addi_q   <= skip_addi_d;
        end
    end

    assign bus.req_ready   = (state_q == ST_IDLE);
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_last  = instr_last_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_alu_op_encoder.sv
// Scoreboard bench for alu_op_encoder: directed requests push expected words
// or error pulses; a negedge monitor pops and compares every DUT output.
module tb_alu_op_encoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_op_encoder_if bus();

    alu_op_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit          is_err;
        logic [31:0] word;
        bit          last;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    task automatic exp_word(input logic [31:0] w, input bit l);
        exp_t e;
        e.is_err = 1'b0; e.word = w; e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic exp_err();
        exp_t e;
        e.is_err = 1'b1; e.word = 32'h0; e.last = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Present one request and hold it until accepted (bounded)
    task automatic send(input logic [3:0] ctrl, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input bit use_imm, input logic [31:0] imm);
        int n;
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_aluctrl = ctrl; bus.req_rd = rd;
        bus.req_rs1 = rs1; bus.req_rs2 = rs2; bus.req_use_imm = use_imm; bus.req_imm = imm;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            checks++; failures++;
            $display("FAIL req_accept_timeout: req_ready stuck at 0 required 1");
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        $display("req ctrl=%b rd=%0d rs1=%0d rs2=%0d imm=%0d val=0x%08h", ctrl, rd, rs1, rs2, use_imm, imm);
    endtask

    // Monitor: pops expectations on word handshakes and err pulses
    initial begin
        bit          stalled = 1'b0;
        bit          prev_err = 1'b0;
        logic [31:0] prev_instr = 32'h0;
        logic        prev_last = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (stalled) begin
                    checks++;
                    if (!bus.instr_valid || bus.instr !== prev_instr || bus.instr_last !== prev_last) begin
                        failures++;
                        $display("FAIL stall_stable: got v=%0b 0x%08h last=%0b required v=1 0x%08h last=%0b",
                                 bus.instr_valid, bus.instr, bus.instr_last, prev_instr, prev_last);
                    end
                end
                if (bus.instr_valid && bus.instr_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_word: got 0x%08h last=%0b required none", bus.instr, bus.instr_last);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.is_err || bus.instr !== e.word || bus.instr_last !== e.last) begin
                            failures++;
                            $display("FAIL word: got 0x%08h last=%0b required %s 0x%08h last=%0b",
                                     bus.instr, bus.instr_last, e.is_err ? "err" : "word", e.word, e.last);
                        end else
                            $display("word 0x%08h last=%0b ok", bus.instr, bus.instr_last);
                    end
                end
                if (bus.err) begin
                    checks++;
                    if (exp_q.size() == 0 || prev_err || bus.instr_valid) begin
                        failures++;
                        $display("FAIL err_pulse: got err=1 prev_err=%0b instr_valid=%0b required single expected pulse",
                                 prev_err, bus.instr_valid);
                        if (exp_q.size() != 0) void'(exp_q.pop_front());
                    end else begin
                        e = exp_q.pop_front();
                        if (!e.is_err) begin
                            failures++;
                            $display("FAIL err_pulse: got err required word 0x%08h", e.word);
                        end else
                            $display("err pulse ok");
                    end
                end
            end
            stalled    = rst_n && bus.instr_valid && !bus.instr_ready;
            prev_instr = bus.instr;
            prev_last  = bus.instr_last;
            prev_err   = rst_n && bus.err;
        end
    end

    initial begin
        int n;
        bus.req_valid = 1'b0; bus.req_aluctrl = 4'h0; bus.req_rd = 5'd0; bus.req_rs1 = 5'd0;
        bus.req_rs2 = 5'd0; bus.req_use_imm = 1'b0; bus.req_imm = 32'h0; bus.instr_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_instr_valid", {31'h0, bus.instr_valid}, 32'h0);
        check("rst_instr", bus.instr, 32'h0);
        check("rst_instr_last", {31'h0, bus.instr_last}, 32'h0);
        check("rst_err", {31'h0, bus.err}, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);

        exp_word(32'h002081B3, 1'b1); send(4'b0000, 5'd3, 5'd1, 5'd2, 1'b0, 32'h0);
        exp_word(32'h407302B3, 1'b1); send(4'b0001, 5'd5, 5'd6, 5'd7, 1'b0, 32'h0);
        exp_word(32'hFFF00093, 1'b1); send(4'b0000, 5'd1, 5'd0, 5'd0, 1'b1, 32'hFFFFFFFF);
        exp_word(32'h0050A113, 1'b1); send(4'b0101, 5'd2, 5'd1, 5'd0, 1'b1, 32'h00000005);

        // srai with consumer stalled for three cycles
        @(posedge clk); #1 bus.instr_ready = 1'b0;
        exp_word(32'h40315113, 1'b1); send(4'b1011, 5'd2, 5'd2, 5'd0, 1'b1, 32'h3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_req_ready", {31'h0, bus.req_ready}, 32'h0);
        end
        @(posedge clk); #1 bus.instr_ready = 1'b1;

        exp_word(32'h123452B7, 1'b0); exp_word(32'h67828293, 1'b0); exp_word(32'h0055F533, 1'b1);
        send(4'b0010, 5'd10, 5'd11, 5'd0, 1'b1, 32'h12345678);
        exp_word(32'h000012B7, 1'b0); exp_word(32'h80028293, 1'b0); exp_word(32'h005080B3, 1'b1);
        send(4'b0000, 5'd1, 5'd1, 5'd0, 1'b1, 32'h00000800);
        exp_word(32'h000032B7, 1'b0); exp_word(32'h005080B3, 1'b1);
        send(4'b0000, 5'd1, 5'd1, 5'd0, 1'b1, 32'h00003000);

        // Error cases: err pulse, req_ready back the following cycle
        for (int k = 0; k < 3; k++) begin
            exp_err();
            case (k)
                0: send(4'b1000, 5'd1, 5'd1, 5'd2, 1'b0, 32'h0);
                1: send(4'b0001, 5'd1, 5'd1, 5'd0, 1'b1, 32'h4);
                default: send(4'b1010, 5'd1, 5'd1, 5'd0, 1'b1, 32'd32);
            endcase
            @(negedge clk);
            @(negedge clk);
            check("err_req_ready_back", {31'h0, bus.req_ready}, 32'h1);
        end

`ifdef ALU_OP_ENCODER_CRYPTO_EN
        exp_word(32'h0031208B, 1'b1);
`else
        exp_err();
`endif
        send(4'b1101, 5'd1, 5'd2, 5'd3, 1'b0, 32'h0);

        // Reset while the LUI word is waiting: the sequence must be abandoned
        @(posedge clk); #1 bus.instr_ready = 1'b0;
        send(4'b0010, 5'd10, 5'd11, 5'd0, 1'b1, 32'h12345678);
        @(negedge clk);
        check("lui_presented", bus.instr, 32'h123452B7);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1; bus.instr_ready = 1'b1;
        @(negedge clk);
        check("rst_mid_instr_valid", {31'h0, bus.instr_valid}, 32'h0);
        check("rst_mid_req_ready", {31'h0, bus.req_ready}, 32'h1);
        repeat (10) @(negedge clk);

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", exp_q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_op_encoder.md
Name: alu_op_encoder

Overview:
- Inverse of the core's ALU control decoding: takes a 4-bit ALUControl operation code plus register/immediate operands and emits legal 32-bit RV32I (plus custom crypto) instruction words.
- Immediates that do not fit 12 bits are expanded into LUI/ADDI/op sequences through a scratch register.
- Sits in the self-test/instruction-injection path, feeding instruction memory or a debug instruction port through a valid/ready stream.

Parameters:
- SCRATCH_REG, 5, destination register used for LUI/ADDI expansion (x5/t0); must be nonzero.
- CRYPTO_OPCODE, 7'b0001011, major opcode for custom crypto ops.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  encoder can accept a request.
- req_aluctrl  in  4  ALUControl code (same code map the core uses).
- req_rd  in  5  destination register.
- req_rs1  in  5  source register 1.
- req_rs2  in  5  source register 2 (ignored when req_use_imm=1).
- req_use_imm  in  1  1 = immediate form.
- req_imm  in  32  immediate value, two's complement.
- instr_valid  out  1  instr holds a word.
- instr_ready  in  1  consumer accepts word.
- instr  out  32  encoded instruction.
- instr_last  out  1  final word of the current request.
- err  out  1  one-cycle pulse: request unencodable, no words emitted.

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE; instr_valid=0, instr=0, instr_last=0, err=0; req_ready=1 from the first cycle after release. Reset mid-sequence abandons the sequence; no further words are emitted.
- Handshakes:
  - Request accepted on req_valid&&req_ready; req_ready=1 only in IDLE.
  - Word transferred on instr_valid&&instr_ready.
  - instr, instr_last and instr_valid are registered and must stay stable while instr_valid=1 and instr_ready=0.
- Opcode and function-field map:
  - R-type (opcode 0110011) / I-type (opcode 0010011).
  - 0000 add/addi f3=000.
  - 0001 sub f3=000 f7=0100000; register form only.
  - 0010 and f3=111. 0011 or f3=110. 0100 xor f3=100.
  - 0101 slt f3=010. 0110 sltu f3=011.
  - 1010 sll f3=001. 1100 srl f3=101 f7=0. 1011 sra f3=101 f7=0100000.
- Immediate form:
  - Short immediate: if req_imm is within [-2048, 2047], emit one I-type word.
  - Shifts: shamt=req_imm[4:0]; req_imm[31:5]!=0 is an error.
  - Long immediate (add/and/or/xor/slt/sltu only):
    - lo = sign-extended req_imm[11:0].
    - hi = (req_imm + 0x800)[31:12], modulo 2^32.
    - Emit LUI SCRATCH_REG,hi; then ADDI SCRATCH_REG,SCRATCH_REG,lo (skipped when lo==0); then R-type op rd,rs1,SCRATCH_REG.
- FSM states: IDLE, LUI, ADDI, OP, ERR.
  - IDLE→LUI, →OP or →ERR on accept. Classification is combinational from request fields; fields are latched on accept.
  - LUI→ADDI (lo!=0) or →OP on word handshake.
  - ADDI→OP on handshake.
  - OP→IDLE on handshake.
  - ERR asserts err for exactly one cycle, then goes to IDLE.
- Latency:
  - First word is valid the cycle after accept.
  - Each subsequent word is valid the cycle after the previous word's handshake.
  - req_ready returns the cycle after the last handshake.
  - Maximum throughput is one word per cycle within a sequence.
- instr_last=1 only on the final word of a request (the single word, or the OP word).
- Errors:
  - Codes 0111, 1000 (AUIPC), 1001 (LUI) and reserved codes.
  - sub with req_use_imm=1.
  - Out-of-range shamt.
  - Long immediate on an op with no expansion.
  - Crypto codes when disabled.

Optional Feature:
- ALU_OP_ENCODER_CRYPTO_EN defined: custom crypto codes are encoded as single R-type words with opcode CRYPTO_OPCODE, f7=0:
  - 1101 ROTL, f3=010.
  - 1110 ROTR, f3=011.
  - 1111 RNG, f3=100, rs1=rs2=0.
  - req_use_imm=1 on a crypto code is an error.
- Undefined: codes 1101/1110/1111 raise err.

Test Plan:
- add rd=3 rs1=1 rs2=2 (reg) -> single word 0x002081B3, instr_last=1; sub rd=5 rs1=6 rs2=7 -> 0x407302B3.
- addi rd=1 rs1=0 imm=-1 -> 0xFFF00093; srai rd=2 rs1=2 imm=3 with instr_ready held 0 for 3 cycles -> 0x40315113 held stable, req_ready=0 throughout.
- and rd=10 rs1=11 imm=0x12345678 -> 0x123452B7, 0x67828293, 0x0055F533, instr_last only on the third; add rd=1 rs1=1 imm=0x800 -> 0x000012B7, 0x80028293, 0x005080B3 (rounding case).
- add rd=1 rs1=1 imm=0x00003000 -> two words, 0x000032B7 then 0x005080B3 (ADDI skipped).
- aluctrl=1000, sub with imm, slli imm=32 -> err one-cycle pulse each, instr_valid stays 0, req_ready back the next cycle; rst_n=0 during the LUI word of a long-imm request -> instr_valid=0 after reset, no OP word ever emitted.
- ROTL rd=1 rs1=2 rs2=3 -> 0x0031208B with ALU_OP_ENCODER_CRYPTO_EN; err pulse without it.
